cacheline_adaptor: RTL and testbench

Memory-side responder for the cache's 256-bit physical-memory interface (pmem_read/pmem_write/pmem_address/pmem_wdata/pmem_rdata/pmem_resp). Each full-line request is converted into a 4-beat, 64-bit burst transaction toward main memory. Sits between the cache (or L2 arbiter) and the burst memory model/controller.

---
 rtl/cacheline_adaptor_pkg.sv | 28 ++
 rtl/cacheline_adaptor_if.sv | 37 +++
 rtl/cacheline_adaptor.sv | 142 ++++++++++++++
 tb/tb_cacheline_adaptor.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cacheline_adaptor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_adaptor_pkg
// Brief    : Shared line/beat types, sizes and FSM encoding for the
//            cacheline-to-burst adaptor.
// Revision : 1.0 - initial release
// ============================================================================
package cacheline_adaptor_pkg;

    localparam int S_LINE          = 256;
    localparam int S_BURST         = 64;
    localparam int S_OFFSET        = 5;
    localparam int BURSTS_PER_LINE = S_LINE / S_BURST;
    localparam int TIMEOUT_CYCLES  = 255;

    typedef logic [S_LINE-1:0]                      cacheline_t;
    typedef logic [S_BURST-1:0]                     burst_t;
    typedef logic [$clog2(BURSTS_PER_LINE)-1:0]     beat_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } adaptor_state_t;

endpackage
`default_nettype wire

// File: rtl/cacheline_adaptor_if.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_adaptor_if
// Brief    : Cache-side line port and memory-side burst port of the adaptor.
// Revision : 1.0 - initial release
// ============================================================================
interface cacheline_adaptor_if;
    import cacheline_adaptor_pkg::*;

    cacheline_t  line_i;
    cacheline_t  line_o;
    logic [31:0] address_i;
    logic        read_i;
    logic        write_i;
    logic        resp_o;
    burst_t      burst_i;
    burst_t      burst_o;
    logic [31:0] address_o;
    logic        read_o;
    logic        write_o;
    logic        resp_i;
    logic        err_o;

    // Requester/memory-model side
    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o, err_o
    );

    // Adaptor side
    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o, err_o
    );

endinterface
`default_nettype wire

// File: rtl/cacheline_adaptor.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_adaptor
// Brief    : Converts 256-bit line reads/writes into 4-beat 64-bit bursts.
//            Optional watchdog abort: CACHELINE_ADAPTOR_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    cacheline_adaptor_if.slave bus
);

    localparam logic [31:0] c_OFFSET_MASK = ~((32'd1 << S_OFFSET) - 32'd1);

    adaptor_state_t r_state;
    beat_t          r_beat;
    cacheline_t     r_line;
    cacheline_t     r_line_o;
    burst_t         r_burst;
    logic [31:0]    r_addr;
    logic           r_read;
    logic           r_write;
    logic           r_resp;

    logic [31:0]    w_addr_aligned;
    beat_t          w_next_beat;
    logic           w_last;

    assign w_addr_aligned = bus.address_i & c_OFFSET_MASK;
    assign w_next_beat    = r_beat + beat_t'(1);
    assign w_last         = (r_beat == beat_t'(BURSTS_PER_LINE - 1));

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    localparam int c_WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_WDOG_W-1:0] r_wdog;
    logic                r_err;
    logic                w_wdog_expired;
    logic                w_busy;

    assign w_busy         = (r_state == READ) || (r_state == WRITE);
    assign w_wdog_expired = (r_wdog == c_WDOG_W'(TIMEOUT_CYCLES - 1));
    assign bus.err_o      = r_err;
`else
    assign bus.err_o      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_beat   <= '0;
            r_line   <= '0;
            r_line_o <= '0;
            r_burst  <= '0;
            r_addr   <= '0;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_resp   <= 1'b0;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
            r_wdog   <= '0;
            r_err    <= 1'b0;
`endif
        end else begin
            r_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.write_i) begin
                        r_line  <= bus.line_i;
                        r_burst <= bus.line_i[S_BURST-1:0];
                        r_addr  <= w_addr_aligned;
                        r_write <= 1'b1;
                        r_state <= WRITE;
                    end else if (bus.read_i) begin
                        r_addr  <= w_addr_aligned;
                        r_read  <= 1'b1;
                        r_state <= READ;
                    end
                end
                READ: begin
                    // Beats assemble in r_line; line_o only changes once the whole line is in.
                    if (bus.resp_i) begin
                        r_line[int'(r_beat)*S_BURST +: S_BURST] <= bus.burst_i;
                        if (w_last) begin
                            r_line_o <= {bus.burst_i, r_line[S_LINE-S_BURST-1:0]};
                            r_read   <= 1'b0;
                            r_resp   <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_beat <= w_next_beat;
                        end
                    end
                end
                WRITE: begin
                    if (bus.resp_i) begin
                        if (w_last) begin
                            r_write <= 1'b0;
                            r_resp  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_beat  <= w_next_beat;
                            r_burst <= r_line[int'(w_next_beat)*S_BURST +: S_BURST];
                        end
                    end
                end
                DONE: begin
                    r_beat  <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
            r_err <= 1'b0;
            if (w_busy && !bus.resp_i) begin
                r_wdog <= r_wdog + c_WDOG_W'(1);
            end else begin
                r_wdog <= '0;
            end
            // Abort overrides the (idle) FSM step; line_o keeps its last good value.
            if (w_busy && !bus.resp_i && w_wdog_expired) begin
                r_read  <= 1'b0;
                r_write <= 1'b0;
                r_err   <= 1'b1;
                r_beat  <= '0;
                r_state <= IDLE;
            end
`endif
        end
    end

    assign bus.line_o    = r_line_o;
    assign bus.resp_o    = r_resp;
    assign bus.burst_o   = r_burst;
    assign bus.address_o = r_addr;
    assign bus.read_o    = r_read;
    assign bus.write_o   = r_write;

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adaptor.sv
`default_nettype none
// ============================================================================
// Module   : tb_cacheline_adaptor
// Brief    : Directed bench for cacheline_adaptor with queue-based scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cacheline_adaptor;
    import cacheline_adaptor_pkg::*;

    typedef struct {
        logic        is_read;
        cacheline_t  line;
        logic [31:0] addr;
        int          cyc;
    } done_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_resp = 0;

    done_t  exp_done[$];
    burst_t exp_beat[$];
    done_t  m_d;
    burst_t m_b;

    cacheline_t L1, LW, LB, L4;

    cacheline_adaptor_if bus();

    cacheline_adaptor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.write_o && bus.resp_i) begin
                if (exp_beat.size() == 0) begin
                    check("unexpected_write_beat", 256'(bus.burst_o), 256'd0);
                end else begin
                    m_b = exp_beat.pop_front();
                    check("burst_o", 256'(bus.burst_o), 256'(m_b));
                end
            end
            if (bus.resp_o) begin
                n_resp++;
                if (exp_done.size() == 0) begin
                    check("unexpected_resp_o", 256'(bus.resp_o), 256'd0);
                end else begin
                    m_d = exp_done.pop_front();
                    check("address_o", 256'(bus.address_o), 256'(m_d.addr));
                    check("resp_o_latency", 256'(cyc), 256'(m_d.cyc));
                    if (m_d.is_read) check("line_o", bus.line_o, m_d.line);
                end
            end
            if (bus.err_o) check("err_o", 256'(bus.err_o), 256'd0);
        end
    end

    // Called at posedge+1 of the request cycle; returns at posedge+1 of cycle 1.
    task automatic start(input logic rd, input logic wr, input logic [31:0] addr, input cacheline_t line);
        bus.read_i    = rd;
        bus.write_i   = wr;
        bus.address_i = addr;
        bus.line_i    = line;
        @(posedge clk); #1;
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
    endtask

    task automatic burst_phase(input cacheline_t data, input bit gaps, input bit is_write);
        for (int k = 0; k < 4; k++) begin
            bus.burst_i = data[k*64 +: 64];
            bus.resp_i  = 1'b1;
            @(negedge clk);
            check("strobe_active", 256'(is_write ? bus.write_o : bus.read_o), 256'd1);
            check("strobe_other", 256'(is_write ? bus.read_o : bus.write_o), 256'd0);
            @(posedge clk); #1;
            bus.resp_i = 1'b0;
            if (gaps && k < 3) begin
                @(negedge clk);
                check("strobe_gap_hold", 256'(is_write ? bus.write_o : bus.read_o), 256'd1);
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_done(input int total);
        for (int i = 0; i < 20 && n_resp < total; i++) begin
            @(posedge clk); #1;
        end
        check("resp_o_count", 256'(n_resp), 256'(total));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        L1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        LW = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        LB = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'h0F0F_0F0F_F0F0_F0F0, 64'hDEAD_BEEF_CAFE_F00D};
        L4 = {64'h8888_7777_6666_5555, 64'h4444_3333_2222_1111,
              64'h1357_9BDF_2468_ACE0, 64'hA5A5_5A5A_C3C3_3C3C};

        bus.line_i    = '0;
        bus.address_i = '0;
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.burst_i   = '0;
        bus.resp_i    = 1'b0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_read_o", 256'(bus.read_o), 256'd0);
        check("rst_write_o", 256'(bus.write_o), 256'd0);
        check("rst_resp_o", 256'(bus.resp_o), 256'd0);
        check("rst_address_o", 256'(bus.address_o), 256'd0);
        check("rst_line_o", bus.line_o, 256'd0);
        check("rst_burst_o", 256'(bus.burst_o), 256'd0);
        @(posedge clk); #1;

        // Back-to-back read
        exp_done.push_back('{is_read: 1'b1, line: L1, addr: 32'h0000_1220, cyc: cyc + 5});
        start(1'b1, 1'b0, 32'h0000_1234, '0);
        burst_phase(L1, 1'b0, 1'b0);
        wait_done(1);
        @(negedge clk);
        check("line_o_hold", bus.line_o, L1);
        @(posedge clk); #1;

        // Write with a gap between every beat
        exp_done.push_back('{is_read: 1'b0, line: '0, addr: 32'h0000_ABC0, cyc: cyc + 8});
        for (int k = 0; k < 4; k++) exp_beat.push_back(LW[k*64 +: 64]);
        start(1'b0, 1'b1, 32'h0000_ABCD, LW);
        burst_phase(LW, 1'b1, 1'b1);
        wait_done(2);
        check("line_o_after_write", bus.line_o, L1);

        // Simultaneous read and write: write wins
        exp_done.push_back('{is_read: 1'b0, line: '0, addr: 32'h0000_0040, cyc: cyc + 5});
        for (int k = 0; k < 4; k++) exp_beat.push_back(LB[k*64 +: 64]);
        start(1'b1, 1'b1, 32'h0000_0040, LB);
        burst_phase(LB, 1'b0, 1'b1);
        wait_done(3);

        // Reset after two read beats
        start(1'b1, 1'b0, 32'h0000_2000, '0);
        bus.resp_i  = 1'b1;
        bus.burst_i = 64'hBAD0_BAD0_BAD0_0001;
        @(posedge clk); #1;
        bus.burst_i = 64'hBAD0_BAD0_BAD0_0002;
        @(posedge clk); #1;
        bus.resp_i = 1'b0;
        rst        = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_read_o", 256'(bus.read_o), 256'd0);
        check("midrst_resp_o", 256'(bus.resp_o), 256'd0);
        check("midrst_address_o", 256'(bus.address_o), 256'd0);
        check("midrst_line_o", bus.line_o, 256'd0);
        @(posedge clk); #1;

        exp_done.push_back('{is_read: 1'b1, line: L4, addr: 32'h0000_3000, cyc: cyc + 5});
        start(1'b1, 1'b0, 32'h0000_301F, '0);
        burst_phase(L4, 1'b0, 1'b0);
        wait_done(4);

        // Spurious resp_i while idle
        bus.burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            bus.resp_i = 1'b1;
            @(negedge clk);
            check("idle_resp_i_outputs", 256'({bus.resp_o, bus.read_o, bus.write_o}), 256'd0);
            @(posedge clk); #1;
        end
        bus.resp_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_line_o_hold", bus.line_o, L4);
        check("final_resp_count", 256'(n_resp), 256'd4);
        check("final_done_queue", 256'(exp_done.size()), 256'd0);
        check("final_beat_queue", 256'(exp_beat.size()), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
